// File: rtl/piso_pkg.sv
// ============================================================================
// Module  : piso_pkg
// Brief   : Shared types and helpers for the PISO serializer slice.
//           Optional parity slot is enabled with `PISO_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    function automatic int bit_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/piso_serializer_if.sv
// ============================================================================
// Module  : piso_serializer_if
// Brief   : Word handshake plus serial output bundle of the PISO serializer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface piso_serializer_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_bit_en;
    logic                  o_x;
    logic                  o_x_valid;
    logic                  o_frame_start;
    logic                  o_busy;

    modport master (
        output i_valid, i_data, i_bit_en,
        input  o_ready, o_x, o_x_valid, o_frame_start, o_busy
    );

    modport slave (
        input  i_valid, i_data, i_bit_en,
        output o_ready, o_x, o_x_valid, o_frame_start, o_busy
    );
endinterface

`default_nettype wire

// File: rtl/piso_shift_reg.sv
// ============================================================================
// Module  : piso_shift_reg
// Brief   : Loadable shift register presenting one serial bit and the parity
//           of the word captured at load.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_shift_reg #(
    parameter int DATA_WIDTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_reset_async,
    input  wire logic                  i_load,
    input  wire logic                  i_shift,
    input  wire logic [DATA_WIDTH-1:0] i_data,
    output logic                       o_bit,
    output logic                       o_parity
);

    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_parity;
    logic [DATA_WIDTH-1:0] w_shifted;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign o_bit     = r_word[DATA_WIDTH-1];
            assign w_shifted = {r_word[DATA_WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign o_bit     = r_word[0];
            assign w_shifted = {1'b0, r_word[DATA_WIDTH-1:1]};
        end
    endgenerate

    // Load wins over shift so a back-to-back word replaces the drained one.
    always_ff @(posedge i_clk or posedge i_reset_async) begin
        if (i_reset_async) begin
            r_word   <= '0;
            r_parity <= 1'b0;
        end else if (i_load) begin
            r_word   <= i_data;
            r_parity <= ^i_data;
        end else if (i_shift) begin
            r_word   <= w_shifted;
        end
    end

    assign o_parity = r_parity;

endmodule

`default_nettype wire

// File: rtl/piso_serializer.sv
// ============================================================================
// Module  : piso_serializer
// Brief   : Parallel-in/serial-out transmitter with valid/ready word intake
//           and bit-enable pacing. `PISO_PARITY_EN appends an even-parity slot.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_serializer
    import piso_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  wire logic         i_clk,
    input  wire logic         i_reset_async,
    piso_serializer_if.slave  bus
);

    localparam int                 c_CNT_W = bit_cnt_w(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_WIDTH - 1);

    state_e             r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic               w_last_slot;
    logic               w_ready;
    logic               w_accept;
    logic               w_load;
    logic               w_shift;
    logic               w_bit;
    logic               w_parity;

    piso_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_shift_reg (
        .i_clk         (i_clk),
        .i_reset_async (i_reset_async),
        .i_load        (w_load),
        .i_shift       (w_shift),
        .i_data        (bus.i_data),
        .o_bit         (w_bit),
        .o_parity      (w_parity)
    );

    always_ff @(posedge i_clk or posedge i_reset_async) begin
        if (i_reset_async) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift     = 1'b0;
`ifdef PISO_PARITY_EN
        w_last_slot = (r_state == PARITY);
`else
        w_last_slot = (r_state == SHIFT) && (r_cnt == c_LAST);
`endif
        // A word can be taken on the tick that retires the final slot.
        w_ready  = !i_reset_async && ((r_state == IDLE) || (w_last_slot && bus.i_bit_en));
        w_accept = bus.i_valid && w_ready;
        w_load   = w_accept;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SHIFT;
                    w_cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (bus.i_bit_en) begin
                    w_shift   = 1'b1;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
`ifdef PISO_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = w_accept ? SHIFT : IDLE;
                        if (w_accept) begin
                            w_cnt_nxt = '0;
                        end
`endif
                    end
                end
            end
            PARITY: begin
`ifdef PISO_PARITY_EN
                if (bus.i_bit_en) begin
                    w_state_nxt = w_accept ? SHIFT : IDLE;
                    if (w_accept) begin
                        w_cnt_nxt = '0;
                    end
                end
`else
                w_state_nxt = IDLE;
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.o_ready       = w_ready;
    assign bus.o_x_valid     = (r_state != IDLE);
    assign bus.o_busy        = (r_state != IDLE);
    assign bus.o_x           = (r_state == PARITY) ? w_parity :
                               (r_state == SHIFT)  ? w_bit    : 1'b0;
    assign bus.o_frame_start = (r_state != IDLE) && (r_cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// ============================================================================
// Module  : tb_piso_serializer
// Brief   : Directed bench driving an MSB-first and an LSB-first serializer
//           with the same stimulus and checking both outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic       bit_en = 1'b0;
    logic [3:0] data = 4'h0;

    int n_vec = 0;
    int n_err = 0;

    piso_serializer_if #(.DATA_WIDTH(4)) if_m ();
    piso_serializer_if #(.DATA_WIDTH(4)) if_l ();

    assign if_m.i_valid  = valid;
    assign if_m.i_data   = data;
    assign if_m.i_bit_en = bit_en;
    assign if_l.i_valid  = valid;
    assign if_l.i_data   = data;
    assign if_l.i_bit_en = bit_en;

    piso_serializer #(.DATA_WIDTH(4), .MSB_FIRST(1)) u_msb (
        .i_clk(clk), .i_reset_async(rst), .bus(if_m)
    );
    piso_serializer #(.DATA_WIDTH(4), .MSB_FIRST(0)) u_lsb (
        .i_clk(clk), .i_reset_async(rst), .bus(if_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [3:0] w, input int k, input bit msb);
        if (k >= 4) return ^w;
        return msb ? w[3-k] : w[k];
    endfunction

    task automatic slot_check(input logic [3:0] w, input int k, input logic rdy);
        chk("x_msb",    if_m.o_x, exp_bit(w, k, 1'b1));
        chk("x_lsb",    if_l.o_x, exp_bit(w, k, 1'b0));
        chk("x_valid",  if_m.o_x_valid, 1'b1);
        chk("busy",     if_l.o_busy, 1'b1);
        chk("fstart_m", if_m.o_frame_start, k == 0);
        chk("fstart_l", if_l.o_frame_start, k == 0);
        chk("ready",    if_m.o_ready, rdy);
    endtask

    task automatic idle_check(input logic rdy);
        chk("idle_x_m",  if_m.o_x, 1'b0);
        chk("idle_x_l",  if_l.o_x, 1'b0);
        chk("idle_xv_m", if_m.o_x_valid, 1'b0);
        chk("idle_xv_l", if_l.o_x_valid, 1'b0);
        chk("idle_fs",   if_m.o_frame_start, 1'b0);
        chk("idle_busy", if_l.o_busy, 1'b0);
        chk("idle_rdy",  if_m.o_ready, rdy);
    endtask

    // One frame with a tick every 'per' cycles; inputs change at negedge.
    task automatic send(input logic [3:0] w, input int per);
        @(negedge clk); valid = 1'b1; data = w; bit_en = 1'b0;
        #1 chk("ready_idle", if_m.o_ready, 1'b1);
        @(negedge clk); valid = 1'b0; data = 4'h0;
        for (int k = 0; k < FL; k++) begin
            for (int h = 0; h < per; h++) begin
                bit_en = (h == per - 1);
                #1 slot_check(w, k, (k == FL - 1) && (h == per - 1));
                @(negedge clk);
            end
        end
        bit_en = 1'b0;
        #1 idle_check(1'b1);
    endtask

    initial begin
        #2 idle_check(1'b0);
        @(negedge clk); rst = 1'b0;
        #1 idle_check(1'b1);

        // Constant tick: 1011 and 0001
        send(4'b1011, 1);
        send(4'b0001, 1);
        // Tick every third cycle
        send(4'hA, 3);

        // Back-to-back A then 5 with no gap
        @(negedge clk); valid = 1'b1; data = 4'hA; bit_en = 1'b1;
        #1 chk("b2b_ready0", if_m.o_ready, 1'b1);
        @(negedge clk); data = 4'h5;
        for (int k = 0; k < FL; k++) begin
            #1 slot_check(4'hA, k, k == FL - 1);
            @(negedge clk);
        end
        valid = 1'b0;
        for (int k = 0; k < FL; k++) begin
            #1 slot_check(4'h5, k, k == FL - 1);
            @(negedge clk);
        end
        bit_en = 1'b0;
        #1 idle_check(1'b1);

        // Reset during bit 2 of 4'hF
        @(negedge clk); valid = 1'b1; data = 4'hF; bit_en = 1'b1;
        @(negedge clk); valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1 slot_check(4'hF, k, 1'b0);
            @(negedge clk);
        end
        #1 slot_check(4'hF, 2, 1'b0);
        #1 rst = 1'b1;
        #1 idle_check(1'b0);
        chk("rst_rdy_l", if_l.o_ready, 1'b0);
        @(negedge clk);
        #1 idle_check(1'b0);
        rst = 1'b0; bit_en = 1'b0;
        #1 idle_check(1'b1);
        send(4'h3, 1);

`ifdef PISO_PARITY_EN
        send(4'b1001, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
